// File: rtl/if_id_skid_buffer_if.sv
// if_id_skid_buffer_if: fetch-side and decode-side handshake bundle for the IF/ID skid buffer.
interface if_id_skid_buffer_if;
    logic        in_valid;
    logic [8:0]  in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        flush_ds;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    modport master (
        output in_valid, in_pc, in_instr, flush, flush_ds, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, flush_ds, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer: 2-entry in-order IF/ID buffer with branch flush, delay-slot retention
// and a saturating count of flushed entries.
module if_id_skid_buffer (
    input  logic              Clk,
    input  logic              Reset,
    if_id_skid_buffer_if.slave b,
    output logic [1:0]        occupancy,
    output logic [7:0]        drop_count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [8:0]  head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [31:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
    logic [7:0]  drop_q, drop_d;
    logic        push, pop, keep;
    logic [2:0]  n_drop;
    logic [8:0]  drop_sum;

    assign b.in_ready  = (state_q != FULL) && !Reset;
    assign b.out_valid = state_q != EMPTY;
    assign b.out_pc    = b.out_valid ? head_pc_q : 9'd0;
    assign b.out_instr = b.out_valid ? head_instr_q : 32'd0;
    assign occupancy   = state_q;
    assign drop_count  = drop_q;
    assign push        = b.in_valid && b.in_ready;
    assign pop         = b.out_valid && b.out_ready;

    // Delay slot: an unpopped head survives, or from EMPTY the entry arriving with the branch.
    assign keep     = b.flush_ds && ((state_q != EMPTY && !pop) || (state_q == EMPTY && push));
    assign n_drop   = {1'b0, state_q} + {2'b0, push} - {2'b0, pop} - {2'b0, keep};
    assign drop_sum = {1'b0, drop_q} + {6'b0, n_drop};

    always_comb begin
        state_d      = state_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        drop_d       = drop_q;
        if (b.flush) begin
            state_d = keep ? ONE : EMPTY;
            drop_d  = drop_sum[8] ? 8'hff : drop_sum[7:0];
            if (keep && state_q == EMPTY) begin
                head_pc_d    = b.in_pc;
                head_instr_d = b.in_instr;
            end
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    state_d      = ONE;
                    head_pc_d    = b.in_pc;
                    head_instr_d = b.in_instr;
                end
                ONE: if (push && pop) begin
                    head_pc_d    = b.in_pc;
                    head_instr_d = b.in_instr;
                end else if (push) begin
                    state_d      = FULL;
                    tail_pc_d    = b.in_pc;
                    tail_instr_d = b.in_instr;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    state_d      = ONE;
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= EMPTY;
            head_pc_q    <= 9'd0;
            head_instr_q <= 32'd0;
            tail_pc_q    <= 9'd0;
            tail_instr_q <= 32'd0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            drop_q       <= drop_d;
        end
    end
endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb_if_id_skid_buffer: hand-derived vector table, drop-count saturation run and
// randomized traffic checked against a queue-based reference model.
module tb_if_id_skid_buffer;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] occupancy;
    logic [7:0] drop_count;
    int         checks = 0;
    int         errors = 0;
    logic       rdy_seen;

    if_id_skid_buffer_if b ();

    if_id_skid_buffer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .b          (b.slave),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst, iv;
        logic [8:0]  pc;
        logic [31:0] ins;
        logic        ordy, fl, ds, rdy;
        logic [1:0]  occ;
        logic [8:0]  opc;
        logic [31:0] oins;
        logic [7:0]  drop;
    } vec_t;

    logic [40:0] q[$];
    int          m_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_out_valid", 64'(b.out_valid), 64'(q.size() > 0));
        chk("m_out_pc", 64'(b.out_pc), q.size() > 0 ? 64'(q[0][40:32]) : 64'd0);
        chk("m_out_instr", 64'(b.out_instr), q.size() > 0 ? 64'(q[0][31:0]) : 64'd0);
        chk("m_occupancy", 64'(occupancy), 64'(q.size()));
        chk("m_drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic step(input logic r, input logic iv, input logic [8:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic ds);
        int pre, kept, d;
        bit push, pop;
        logic [40:0] e;
        @(negedge Clk);
        Reset = r; b.in_valid = iv; b.in_pc = pc; b.in_instr = ins;
        b.out_ready = ordy; b.flush = fl; b.flush_ds = ds;
        #1;
        pre  = q.size();
        push = iv && pre < 2 && !r;
        pop  = pre > 0 && ordy;
        rdy_seen = b.in_ready;
        chk("m_in_ready", 64'(b.in_ready), 64'(pre < 2 && !r));
        if (r) begin
            q.delete();
            m_drop = 0;
        end else if (fl) begin
            kept = 0;
            if (ds && pre > 0 && !pop) begin
                e = q[0];
                q.delete();
                q.push_back(e);
                kept = 1;
            end else if (ds && pre == 0 && push) begin
                q.push_back({pc, ins});
                kept = 1;
            end else q.delete();
            d = m_drop + pre + int'(push) - int'(pop) - kept;
            m_drop = d > 255 ? 255 : d;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({pc, ins});
        end
        @(posedge Clk);
        #1;
        check_model();
    endtask

    function automatic vec_t mk(int r, int iv, int pc, int ins, int ordy, int fl, int ds,
                                int rdy, int occ, int opc, int oins, int drop);
        mk.rst = r[0]; mk.iv = iv[0]; mk.pc = pc[8:0]; mk.ins = ins;
        mk.ordy = ordy[0]; mk.fl = fl[0]; mk.ds = ds[0]; mk.rdy = rdy[0];
        mk.occ = occ[1:0]; mk.opc = opc[8:0]; mk.oins = oins; mk.drop = drop[7:0];
    endfunction

    localparam int K = 32'hC0DE0000;
    vec_t vt[23];

    initial begin
        b.in_valid = 1'b0; b.in_pc = 9'd0; b.in_instr = 32'd0;
        b.out_ready = 1'b0; b.flush = 1'b0; b.flush_ds = 1'b0;
        vt[0]  = mk(1, 1, 'h003, K | 'h003, 0, 0, 0, 0, 0, 'h000, 0, 0);
        vt[1]  = mk(0, 1, 'h000, 32'h20080005, 1, 0, 0, 1, 1, 'h000, 32'h20080005, 0);
        vt[2]  = mk(0, 0, 'h000, 0, 1, 0, 0, 1, 0, 'h000, 0, 0);
        vt[3]  = mk(0, 1, 'h000, K | 'h000, 0, 0, 0, 1, 1, 'h000, K | 'h000, 0);
        vt[4]  = mk(0, 1, 'h004, K | 'h004, 0, 0, 0, 1, 2, 'h000, K | 'h000, 0);
        vt[5]  = mk(0, 1, 'h008, K | 'h008, 0, 0, 0, 0, 2, 'h000, K | 'h000, 0);
        vt[6]  = mk(0, 0, 'h008, K | 'h008, 1, 0, 0, 0, 1, 'h004, K | 'h004, 0);
        vt[7]  = mk(0, 1, 'h008, K | 'h008, 1, 0, 0, 1, 1, 'h008, K | 'h008, 0);
        vt[8]  = mk(0, 0, 'h000, 0, 1, 0, 0, 1, 0, 'h000, 0, 0);
        vt[9]  = mk(0, 1, 'h010, K | 'h010, 0, 0, 0, 1, 1, 'h010, K | 'h010, 0);
        vt[10] = mk(0, 1, 'h014, K | 'h014, 0, 0, 0, 1, 2, 'h010, K | 'h010, 0);
        vt[11] = mk(0, 0, 'h000, 0, 0, 1, 0, 0, 0, 'h000, 0, 2);
        vt[12] = mk(0, 1, 'h010, K | 'h010, 0, 0, 0, 1, 1, 'h010, K | 'h010, 2);
        vt[13] = mk(0, 1, 'h014, K | 'h014, 0, 0, 0, 1, 2, 'h010, K | 'h010, 2);
        vt[14] = mk(0, 0, 'h000, 0, 0, 1, 1, 0, 1, 'h010, K | 'h010, 3);
        vt[15] = mk(0, 0, 'h000, 0, 0, 0, 1, 1, 1, 'h010, K | 'h010, 3);
        vt[16] = mk(0, 0, 'h000, 0, 1, 1, 1, 1, 0, 'h000, 0, 3);
        vt[17] = mk(0, 1, 'h020, K | 'h020, 0, 1, 1, 1, 1, 'h020, K | 'h020, 3);
        vt[18] = mk(0, 1, 'h024, K | 'h024, 0, 1, 0, 1, 0, 'h000, 0, 5);
        vt[19] = mk(0, 1, 'h030, K | 'h030, 0, 0, 0, 1, 1, 'h030, K | 'h030, 5);
        vt[20] = mk(0, 1, 'h034, K | 'h034, 0, 0, 0, 1, 2, 'h030, K | 'h030, 5);
        vt[21] = mk(1, 1, 'h038, K | 'h038, 0, 0, 0, 0, 0, 'h000, 0, 0);
        vt[22] = mk(0, 0, 'h000, 0, 0, 0, 0, 1, 0, 'h000, 0, 0);

        step(1'b1, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 23; i++) begin
            step(vt[i].rst, vt[i].iv, vt[i].pc, vt[i].ins, vt[i].ordy, vt[i].fl, vt[i].ds);
            chk($sformatf("tv%0d_in_ready", i), 64'(rdy_seen), 64'(vt[i].rdy));
            chk($sformatf("tv%0d_occupancy", i), 64'(occupancy), 64'(vt[i].occ));
            chk($sformatf("tv%0d_out_valid", i), 64'(b.out_valid), 64'(vt[i].occ != 2'd0));
            chk($sformatf("tv%0d_out_pc", i), 64'(b.out_pc), 64'(vt[i].opc));
            chk($sformatf("tv%0d_out_instr", i), 64'(b.out_instr), 64'(vt[i].oins));
            chk($sformatf("tv%0d_drop_count", i), 64'(drop_count), 64'(vt[i].drop));
        end

        for (int k = 1; k <= 130; k++) begin
            step(1'b0, 1'b1, 9'(2 * k), 32'(k), 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b1, 9'(2 * k + 1), 32'(k), 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b1, 1'b0);
            if (k == 127) chk("sat_254", 64'(drop_count), 64'd254);
        end
        chk("sat_255", 64'(drop_count), 64'd255);
        step(1'b0, 1'b1, 9'h1f0, 32'h1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 9'h1f4, 32'h2, 1'b0, 1'b1, 1'b0);
        chk("sat_hold", 64'(drop_count), 64'd255);
        step(1'b1, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_drop", 64'(drop_count), 64'd0);

        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 9'($urandom), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
